// File: rtl/dm_access_ctrl.sv
// Byte-wide data-memory initiator: splits one load/store into 1/2/4 little-endian byte beats.
// Optional DM_ALIGN_CHECK_EN rejects misaligned half/word accesses with rsp_err instead of issuing beats.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a request; req_ready high once out of reset
// S_ISSUE | one byte beat on the memory port per cycle
// S_DRAIN | load only: capture the last read byte, build the response
// S_RESP  | rsp_valid pulse, then back to idle
module dm_access_ctrl #(
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [2:0]    req_type,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   input  logic [7:0]    mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESP} state_t;

   state_t        r_state;
   logic          r_ready;
   logic          r_we;
   logic [2:0]    r_type;
   logic [31:0]   r_wdata;
   logic [1:0]    r_beat;
   logic [1:0]    r_last;
   logic [31:0]   r_asm;
   logic          r_rsp_valid;
   logic [31:0]   r_rsp_rdata;
   logic          r_rsp_err;
   logic          r_mem_en;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_addr;
   logic [7:0]    r_mem_wdata;

   logic [1:0]    w_req_last;
   logic          w_type_ok;
   logic          w_misalign;
   logic [1:0]    w_beat_nxt;
   logic [1:0]    w_beat_prev;
   logic [31:0]   w_asm_fill;
   logic [31:0]   w_ext;

   always_comb begin
      w_req_last = 2'd0;
      case (req_type)
         3'b000:         w_req_last = 2'd3;
         3'b001, 3'b010: w_req_last = 2'd1;
         default:        w_req_last = 2'd0;
      endcase
   end

   assign w_type_ok = (req_type <= 3'd4);

`ifdef DM_ALIGN_CHECK_EN
   assign w_misalign = ((req_type == 3'b001 || req_type == 3'b010) && req_addr[0]) ||
                       (req_type == 3'b000 && req_addr[1:0] != 2'b00);
`else
   assign w_misalign = 1'b0;
`endif

   assign w_beat_nxt  = r_beat + 2'd1;
   assign w_beat_prev = r_beat - 2'd1;

   // The last read byte arrives during DRAIN; merge it before extending.
   always_comb begin
      w_asm_fill = r_asm;
      w_asm_fill[{r_last, 3'b000} +: 8] = mem_rdata;
   end

   always_comb begin
      w_ext = w_asm_fill;
      case (r_type)
         3'b001:  w_ext = {{16{w_asm_fill[15]}}, w_asm_fill[15:0]};
         3'b010:  w_ext = {16'h0000, w_asm_fill[15:0]};
         3'b011:  w_ext = {{24{w_asm_fill[7]}}, w_asm_fill[7:0]};
         3'b100:  w_ext = {24'h000000, w_asm_fill[7:0]};
         default: w_ext = w_asm_fill;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ready     <= 1'b0;
         r_we        <= 1'b0;
         r_type      <= 3'b000;
         r_wdata     <= 32'h0;
         r_beat      <= 2'd0;
         r_last      <= 2'd0;
         r_asm       <= 32'h0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'h0;
         r_rsp_err   <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 8'h00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid && r_ready) begin
                  r_ready <= 1'b0;
                  r_we    <= req_we;
                  r_type  <= req_type;
                  r_wdata <= req_wdata;
                  r_asm   <= 32'h0;
                  r_beat  <= 2'd0;
                  r_last  <= w_req_last;
                  if (!w_type_ok || w_misalign) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_rdata <= 32'h0;
                     r_rsp_err   <= w_misalign;
                     r_state     <= S_RESP;
                  end else begin
                     // Beat 0 goes out in the first cycle after acceptance.
                     r_mem_en    <= 1'b1;
                     r_mem_we    <= req_we;
                     r_mem_addr  <= req_addr;
                     r_mem_wdata <= req_wdata[7:0];
                     r_state     <= S_ISSUE;
                  end
               end else begin
                  r_ready <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (r_beat != 2'd0 && !r_we)
                  r_asm[{w_beat_prev, 3'b000} +: 8] <= mem_rdata;
               if (r_beat == r_last) begin
                  r_mem_en <= 1'b0;
                  r_mem_we <= 1'b0;
                  if (r_we) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_rdata <= 32'h0;
                     r_rsp_err   <= 1'b0;
                     r_state     <= S_RESP;
                  end else begin
                     r_state <= S_DRAIN;
                  end
               end else begin
                  r_beat      <= w_beat_nxt;
                  r_mem_addr  <= r_mem_addr + AW'(1);
                  r_mem_wdata <= r_wdata[{w_beat_nxt, 3'b000} +: 8];
               end
            end
            S_DRAIN: begin
               r_asm       <= w_asm_fill;
               r_rsp_valid <= 1'b1;
               r_rsp_rdata <= w_ext;
               r_rsp_err   <= 1'b0;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               r_rsp_valid <= 1'b0;
               r_rsp_err   <= 1'b0;
               r_ready     <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready = r_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: table of load/store requests against a byte memory model,
// plus a reset-during-store sequence. Expectations follow DM_ALIGN_CHECK_EN when it is defined.
module tb_dm_access_ctrl;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [2:0]    req_type = 3'b000;
   logic [AW-1:0] req_addr = '0;
   logic [31:0]   req_wdata = 32'h0;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata = 8'h5A;

   logic [7:0]    mem [64];

   int n_checks = 0;
   int n_errors = 0;

   dm_access_ctrl #(.AW(AW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Byte memory: writes on the strobe edge, read data valid the following cycle, junk otherwise.
   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
      else mem_rdata <= 8'h5A;
   end

   typedef struct {
      logic        we;
      logic [2:0]  typ;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_beats;
   } vec_t;

   vec_t vtab[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_alog(input logic [7:0] addr, input int n);
      logic [31:0] a = 32'h0;
      for (int k = 0; k < n; k++) a[8*k +: 8] = (addr + 8'(k)) & 8'h3F;
      return a;
   endfunction

   function automatic vec_t mk(input logic we, input logic [2:0] typ, input logic [7:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rd, input logic err,
                               input int lat, input int beats);
      vec_t v;
      v.we = we; v.typ = typ; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = rd; v.exp_err = err; v.exp_lat = lat; v.exp_beats = beats;
      return v;
   endfunction

   task automatic run_vec(input int idx, input vec_t v);
      int          bound;
      int          beats;
      int          lat;
      logic        got;
      logic        we_bad;
      logic [31:0] alog;
      logic [31:0] wlog;
      logic [31:0] rd;
      logic [31:0] wmask;
      logic        er;
      logic        rdy;
      string       tag;
      tag = $sformatf("v%0d", idx);
      bound = 0;
      while (!req_ready && bound < 20) begin
         @(posedge clk); #1;
         bound++;
      end
      chk({tag, "_ready_idle"}, req_ready, 1);
      req_valid = 1'b1;
      req_we    = v.we;
      req_type  = v.typ;
      req_addr  = v.addr[AW-1:0];
      req_wdata = v.wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      beats = 0; lat = 0; got = 1'b0; we_bad = 1'b0;
      alog = 32'h0; wlog = 32'h0; rd = 32'h0; er = 1'b0; rdy = 1'b0;
      for (int c = 1; c <= 20 && !got; c++) begin
         if (mem_en) begin
            if (beats < 4) begin
               alog[8*beats +: 8] = {2'b00, mem_addr};
               wlog[8*beats +: 8] = mem_wdata;
            end
            if (mem_we !== v.we) we_bad = 1'b1;
            beats++;
         end
         if (rsp_valid) begin
            got = 1'b1; lat = c; rd = rsp_rdata; er = rsp_err; rdy = req_ready;
         end else begin
            @(posedge clk); #1;
         end
      end
      chk({tag, "_rsp_seen"}, got, 1);
      chk({tag, "_latency"}, lat, v.exp_lat);
      chk({tag, "_beats"}, beats, v.exp_beats);
      chk({tag, "_rdata"}, rd, v.exp_rdata);
      chk({tag, "_err"}, er, v.exp_err);
      chk({tag, "_ready_in_resp"}, rdy, 0);
      chk({tag, "_mem_we"}, we_bad, 0);
      chk({tag, "_addr_seq"}, alog, exp_alog(v.addr, v.exp_beats));
      if (v.we && v.exp_beats > 0) begin
         wmask = (v.exp_beats == 4) ? 32'hFFFFFFFF : (v.exp_beats == 2) ? 32'h0000FFFF : 32'h000000FF;
         chk({tag, "_wdata_seq"}, wlog, v.wdata & wmask);
      end
      @(posedge clk); #1;
      chk({tag, "_rsp_pulse"}, rsp_valid, 0);
      chk({tag, "_ready_after"}, req_ready, 1);
   endtask

   initial begin
      int   seen;
      vec_t v;
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;

      vtab[0]  = mk(1, 3'b000, 8'h10, 32'h89ABCDEF, 32'h00000000, 0, 5, 4);
      vtab[1]  = mk(0, 3'b011, 8'h12, 32'h0,        32'hFFFFFFAB, 0, 3, 1);
      vtab[2]  = mk(0, 3'b010, 8'h12, 32'h0,        32'h000089AB, 0, 4, 2);
      vtab[3]  = mk(0, 3'b001, 8'h12, 32'h0,        32'hFFFF89AB, 0, 4, 2);
      vtab[4]  = mk(0, 3'b000, 8'h10, 32'h0,        32'h89ABCDEF, 0, 6, 4);
      vtab[5]  = mk(0, 3'b100, 8'h13, 32'h0,        32'h00000089, 0, 3, 1);
      vtab[6]  = mk(0, 3'b011, 8'h10, 32'h0,        32'hFFFFFFEF, 0, 3, 1);
      vtab[9]  = mk(1, 3'b011, 8'h20, 32'hAAAAAA7F, 32'h00000000, 0, 2, 1);
      vtab[10] = mk(0, 3'b011, 8'h20, 32'h0,        32'h0000007F, 0, 3, 1);
      vtab[11] = mk(1, 3'b010, 8'h22, 32'h12348001, 32'h00000000, 0, 3, 2);
      vtab[12] = mk(0, 3'b001, 8'h22, 32'h0,        32'hFFFF8001, 0, 4, 2);
      vtab[13] = mk(0, 3'b000, 8'h20, 32'h0,        32'h8001007F, 0, 6, 4);
      vtab[14] = mk(0, 3'b101, 8'h10, 32'h0,        32'h00000000, 0, 1, 0);
      vtab[15] = mk(1, 3'b111, 8'h10, 32'hFFFFFFFF, 32'h00000000, 0, 1, 0);
      vtab[19] = mk(0, 3'b100, 8'h13, 32'h0,        32'h00000089, 0, 3, 1);
`ifdef DM_ALIGN_CHECK_EN
      vtab[7]  = mk(1, 3'b000, 8'h3E, 32'h11223344, 32'h00000000, 1, 1, 0);
      vtab[8]  = mk(0, 3'b000, 8'h3E, 32'h0,        32'h00000000, 1, 1, 0);
      vtab[16] = mk(0, 3'b001, 8'h11, 32'h0,        32'h00000000, 1, 1, 0);
      vtab[17] = mk(1, 3'b001, 8'h3F, 32'h0000BEEF, 32'h00000000, 1, 1, 0);
      vtab[18] = mk(0, 3'b100, 8'h00, 32'h0,        32'h00000000, 0, 3, 1);
`else
      vtab[7]  = mk(1, 3'b000, 8'h3E, 32'h11223344, 32'h00000000, 0, 5, 4);
      vtab[8]  = mk(0, 3'b000, 8'h3E, 32'h0,        32'h11223344, 0, 6, 4);
      vtab[16] = mk(0, 3'b001, 8'h11, 32'h0,        32'hFFFFABCD, 0, 4, 2);
      vtab[17] = mk(1, 3'b001, 8'h3F, 32'h0000BEEF, 32'h00000000, 0, 3, 2);
      vtab[18] = mk(0, 3'b100, 8'h00, 32'h0,        32'h000000BE, 0, 3, 1);
`endif

      #2;
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", {26'h0, mem_addr}, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      #10 rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_ready", req_ready, 1);

      for (int i = 0; i < 20; i++) run_vec(i, vtab[i]);

      // Reset during the second beat of a word store.
      req_valid = 1'b1; req_we = 1'b1; req_type = 3'b000;
      req_addr = 6'h30; req_wdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("abort_beat0_en", mem_en, 1);
      chk("abort_beat0_addr", {26'h0, mem_addr}, 32'h30);
      @(posedge clk); #1;
      chk("abort_beat1_addr", {26'h0, mem_addr}, 32'h31);
      rst = 1'b1;
      #1;
      chk("abort_mem_en", mem_en, 0);
      chk("abort_mem_we", mem_we, 0);
      chk("abort_mem_addr", {26'h0, mem_addr}, 0);
      chk("abort_mem_wdata", mem_wdata, 0);
      chk("abort_ready", req_ready, 0);
      chk("abort_rsp_valid", rsp_valid, 0);
      @(posedge clk); #1;
      chk("abort_ready_held", req_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_ready_after", req_ready, 1);
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (rsp_valid) seen++;
         @(posedge clk); #1;
      end
      chk("abort_no_rsp", seen, 0);
      chk("abort_byte0_kept", mem[6'h30], 8'hEF);
      chk("abort_byte1_unwritten", mem[6'h31], 8'h00);
      v = mk(0, 3'b000, 8'h30, 32'h0, 32'h000000EF, 0, 6, 4);
      run_vec(20, v);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
